// File: rtl/branch_pkg.sv
// branch_pkg: branch opcode encoding and target width shared by the branch unit
package branch_pkg;
    localparam int TGT_W = 9;
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_BEQ  = 3'd2,
        BR_BNE  = 3'd3,
        BR_BLT  = 3'd4,
        BR_BCS  = 3'd5,
        BR_CALL = 3'd6,
        BR_RET  = 3'd7
    } br_op_t;
endpackage

// File: rtl/branch_ctl_if.sv
// branch_ctl_if: decode/fetch-side bundle of the branch-resolution unit
interface branch_ctl_if import branch_pkg::*; #(
    parameter int T = 10,
    parameter int D = 4
);
    logic                     Start;
    br_op_t                   BrOp;
    logic [TGT_W-1:0]         Offset;
    logic                     FlagWr;
    logic                     AluZero;
    logic                     AluNeg;
    logic                     AluCarry;
    logic [T-1:0]             ProgCtr;
    logic                     CMP_Flag;
    logic [TGT_W-1:0]         Target;
    logic [$clog2(D+1)-1:0]   StackDepth;
    logic                     Err;
    modport master (
        output Start, BrOp, Offset, FlagWr, AluZero, AluNeg, AluCarry, ProgCtr,
        input  CMP_Flag, Target, StackDepth, Err
    );
    modport slave (
        input  Start, BrOp, Offset, FlagWr, AluZero, AluNeg, AluCarry, ProgCtr,
        output CMP_Flag, Target, StackDepth, Err
    );
endinterface

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses; pushes when full and pops when empty are ignored
module ret_stack #(
    parameter int T = 10,
    parameter int D = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [T-1:0]             din,
    output logic [T-1:0]             top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(D+1)-1:0]   depth
);
    localparam int AW = $clog2(D + 1);
    logic [T-1:0]  mem_q [D];
    logic [T-1:0]  mem_d [D];
    logic [AW-1:0] depth_q, depth_d;
    assign full  = depth_q == AW'(D);
    assign empty = depth_q == '0;
    assign depth = depth_q;
    always_comb begin
        mem_d   = mem_q;
        top     = '0;
        for (int i = 0; i < D; i++) begin
            if (push && !full && depth_q == AW'(i)) mem_d[i] = din;
            if (depth_q == AW'(i + 1)) top = mem_q[i];
        end
        depth_d = clr ? '0 :
                  (push && !full) ? depth_q + AW'(1) :
                  (pop && !empty) ? depth_q - AW'(1) : depth_q;
    end
    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        depth_q <= depth_d;
    end
endmodule

// File: rtl/branch_ctl.sv
// branch_ctl: branch resolution with optional hardware return stack (BRANCH_RAS_EN)
module branch_ctl import branch_pkg::*; #(
    parameter int T = 10,
    parameter int D = 4
) (
    input logic         Clk,
    input logic         Reset,
    branch_ctl_if.slave bus
);
    localparam int SW = $clog2(D + 1);
    logic             clr, take, fault, err_q, err_d;
    logic [2:0]       flags_q, flags_d;
    logic [TGT_W-1:0] tgt;
    assign clr = Reset | bus.Start;
`ifdef BRANCH_RAS_EN
    logic          push, pop, full, empty;
    logic [T-1:0]  top, diff;
    logic [SW-1:0] depth;
    assign diff = top - bus.ProgCtr;
    ret_stack #(.T(T), .D(D)) u_stack (
        .clk(Clk), .clr(clr), .push(push), .pop(pop), .din(bus.ProgCtr + T'(1)),
        .top(top), .full(full), .empty(empty), .depth(depth)
    );
    assign bus.StackDepth = depth;
`else
    logic [T-1:0] unused_pc;
    assign unused_pc      = bus.ProgCtr;
    assign bus.StackDepth = SW'(0);
`endif
    always_comb begin
        flags_d = clr ? 3'b000 : bus.FlagWr ? {bus.AluZero, bus.AluNeg, bus.AluCarry} : flags_q;
        take    = 1'b0;
        tgt     = bus.Offset;
        fault   = 1'b0;
`ifdef BRANCH_RAS_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (bus.BrOp)
            BR_NONE: ;
            BR_JMP:  take = 1'b1;
            BR_BEQ:  take = flags_q[2];
            BR_BNE:  take = !flags_q[2];
            BR_BLT:  take = flags_q[1];
            BR_BCS:  take = flags_q[0];
            BR_CALL: begin
                take = 1'b1;
`ifdef BRANCH_RAS_EN
                push  = 1'b1;
                fault = full;
`endif
            end
            BR_RET: begin
`ifdef BRANCH_RAS_EN
                // a return too far away for the 9-bit relative target still pops
                pop   = !empty;
                take  = !empty && (diff >> TGT_W) == '0;
                tgt   = TGT_W'(diff);
                fault = !take;
`else
                fault = 1'b1;
`endif
            end
            default: fault = 1'b1;
        endcase
        if (clr) begin
            take  = 1'b0;
            fault = 1'b0;
`ifdef BRANCH_RAS_EN
            push  = 1'b0;
            pop   = 1'b0;
`endif
        end
        err_d = !clr && (err_q || fault);
    end
    assign bus.CMP_Flag = take;
    assign bus.Target   = take ? tgt : '0;
    assign bus.Err      = err_q;
    always_ff @(posedge Clk) begin
        flags_q <= flags_d;
        err_q   <= err_d;
    end
endmodule

// File: doc/branch_ctl.md
# branch_ctl

Branch-resolution unit feeding the instruction-fetch stage. Each cycle it takes the decoded branch opcode, a registered copy of the ALU condition flags and the current program counter. It drives the fetch unit's `CMP_Flag` (take) and 9-bit relative `Target`. A small return-address stack provides gosub/return (CALL/RET) in hardware.

## Interface
Parameters:
- `T`, 10: program-counter width; must match the fetch unit.
- `D`, 4: return-stack depth (entries); minimum 1.

Ports:
- `Clk`  in  1: single clock; all state changes on posedge.
- `Reset`  in  1: synchronous, active-high; clears all state.
- `Start`  in  1: program-start request; same clearing effect as `Reset`.
- `BrOp`  in  3: decoded branch op of the current instruction (`br_op_t`).
- `Offset`  in  9: unsigned forward offset from the instruction field.
- `FlagWr`  in  1: latch the ALU flags this cycle.
- `AluZero`, `AluNeg`, `AluCarry`  in  1 each: ALU result flags.
- `ProgCtr`  in  T: current PC from fetch.
- `CMP_Flag`  out  1: take branch; fetch adds `Target` to PC.
- `Target`  out  9: relative offset, zero-extended by fetch.
- `StackDepth`  out  $clog2(D+1): occupied return-stack entries.
- `Err`  out  1: sticky fault flag.

## Operation
- Flag register `{Z,N,C}` is loaded from the ALU on `FlagWr`. Branch decisions always use the registered value, never the live ALU flags.
- `BR_NONE`: `CMP_Flag`=0.
- `BR_JMP`: `CMP_Flag`=1, `Target`=`Offset`.
- `BR_BEQ`: take if Z=1. `BR_BNE`: take if Z=0. `BR_BLT`: take if N=1. `BR_BCS`: take if C=1. For these ops, `Target`=`Offset`.
- `BR_CALL`: take, `Target`=`Offset`; push `ProgCtr+1` (mod 2^T).
- `BR_RET`: pop top entry R; compute `Target` = (R − `ProgCtr`) mod 2^T.
  - Take only if that value < 512.
  - Otherwise pop anyway, `CMP_Flag`=0 (PC increments) and set `Err`.
- CALL with stack full: branch is still taken, push is dropped, `Err` set.
- RET with stack empty: `CMP_Flag`=0, no pop, `Err` set.
- `Target`=0 whenever `CMP_Flag`=0.
- `Err` is cleared only by `Reset` or `Start`.
- Undefined `BrOp` encodings behave as `BR_NONE` and set `Err`.

## Timing
- `CMP_Flag` and `Target` are combinational from `BrOp`, `Offset`, `ProgCtr` and registered state, so fetch samples them at the same posedge. Decision latency is 0 cycles.
- Stack pointer and flag updates take effect at the posedge ending the cycle. A branch in the same cycle as `FlagWr` sees the old flags; the next cycle sees the new ones.
- While `Reset` or `Start` is high, `CMP_Flag`=0 and no push, pop or flag write occurs. At the following edge, stack is emptied, flags are 000 and `Err`=0.
- Reset values: `CMP_Flag`=0, `Target`=0, `StackDepth`=0, `Err`=0.
- Reset or Start asserted mid-sequence (stack non-empty) discards all entries in one cycle.
- Push and pop never coincide: each instruction carries a single op.

## Configuration
- `BRANCH_RAS_EN` defined: return stack, CALL/RET behaviour and `StackDepth` as above.
- Undefined: no stack is built.
  - CALL behaves exactly as JMP.
  - RET behaves as `BR_NONE` and sets `Err`.
  - `StackDepth` is tied to 0.

## Structure
- Package `branch_pkg`: `br_op_t` enum (NONE=0, JMP=1, BEQ=2, BNE=3, BLT=4, BCS=5, CALL=6, RET=7) and the localparam `TGT_W=9`.
- Sub-module `ret_stack`, parameterised on T and D. It exposes `push`, `pop`, `din`, `top`, `full`, `empty` and `depth`, with a synchronous clear. It is instantiated only under `BRANCH_RAS_EN`.

## Test plan
- Reset, then `FlagWr` with Zero=1, then BEQ with Offset=5 → the cycle after `FlagWr` gives `CMP_Flag`=1, `Target`=5. A BEQ in the same cycle as `FlagWr` (old Z=0) gives `CMP_Flag`=0.
- CALL at PC=0x010 (Offset=0x20), then RET at PC=0x035 → RET gives `Target`=(0x011−0x035) mod 1024=0x3DC ≥ 512, so `CMP_Flag`=0, `Err`=1, `StackDepth` 1→0.
- Set T=9: CALL at PC=0x0F0, RET at PC=0x100 → `Target`=0x1F1, `CMP_Flag`=1, `Err`=0.
- D=4: five consecutive CALLs → `StackDepth` saturates at 4, all five taken, `Err`=1. Four RETs return in LIFO order; a fifth RET gives `CMP_Flag`=0.
- Stack depth 3, assert `Start` for one cycle → `CMP_Flag`=0 during Start, then `StackDepth`=0, flags 000, `Err`=0. A following RET sets `Err`.
- Build without `BRANCH_RAS_EN`: CALL Offset=7 → `CMP_Flag`=1, `Target`=7, `StackDepth`=0. RET → `CMP_Flag`=0, `Err`=1.
